ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//   Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU. Sits in the EX stage and consumes
//   ex_reg1/ex_reg2 as captured by the ID/EX pipeline register.
//   Holds the pipeline through stall_req_o until the quotient or remainder is ready.
//   Returns the selected result to EX for forwarding into EX/MEM.
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count = WIDTH; counter width = clog2(WIDTH)+1
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   start_i      in   1      EX holds a divide op; must stay high until ready_o is seen
//   signed_i     in   1      1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   rem_i        in   1      1 = return remainder, 0 = return quotient
//   dividend_i   in   WIDTH  rs1 value (ex_reg1)
//   divisor_i    in   WIDTH  rs2 value (ex_reg2)
//   annul_i      in   1      flush: abort the operation in flight
//   result_o     out  WIDTH  quotient/remainder; valid only while ready_o=1, else 0
//   ready_o      out  1      result valid
//   stall_req_o  out  1      combinational: start_i & ~ready_o & ~annul_i
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, result_o=0, ready_o=0, counter=0, internal regs=0.
// - States:
//   - IDLE
//     - start_i=1 & ~annul_i: sample operands, signed_i and rem_i.
//     - divisor==0 or signed overflow (0x80000000 / 0xFFFFFFFF with signed_i=1): go to DONE.
//     - Otherwise: go to CALC with counter=0.
//   - CALC
//     - Each cycle performs one restoring step: partial remainder {rem,quo} shifts left 1.
//     - rem - |divisor|: if non-negative, keep the difference and set quo LSB=1.
//     - Counter increments; after WIDTH steps (counter==WIDTH-1 step done) go to DONE.
//   - DONE
//     - ready_o=1; result_o holds the sign-corrected value.
//     - Stays in DONE while start_i=1.
//     - start_i=0 gives IDLE next cycle, with ready_o=0 and result_o=0 on that edge.
// - Latency, start first seen in IDLE at edge T:
//   - Normal op: ready_o high after edge T+1+WIDTH (33 cycles for WIDTH=32).
//   - Special cases: ready_o high after edge T+1.
// - Signed handling: the unsigned core runs on |dividend| and |divisor|.
//   - The quotient is negated if the operand signs differ.
//   - The remainder takes the sign of the dividend.
//   - |0x80000000| is handled as unsigned 0x80000000 (no overflow in the core).
// - Special results, per the RISC-V spec:
//   - Divide by zero: quotient=all ones, remainder=dividend.
//   - Signed overflow: quotient=0x80000000, remainder=0.
// - Operands are latched at start.
//   - Changes on dividend_i/divisor_i/signed_i/rem_i during CALC/DONE are ignored.
// - annul_i=1 in any state: IDLE at the next edge, ready_o=0, result_o=0.
//   - annul_i has priority over start_i in the same cycle.
// - start_i dropping during CALC (pipeline redirect): abort to IDLE next edge, no result.
// - start_i held high in DONE: no new operation starts until start_i has been low one cycle in IDLE.
//   - Back-to-back divides therefore need start_i low for at least one cycle between them.
// TESTING
// - DIVU 100/7, start_i held:
//   - ready_o rises 33 cycles after start; result_o=14; REMU gives 2.
//   - stall_req_o=1 for exactly the 33 cycles before ready_o.
// - DIV -7/2 (0xFFFFFFF9/0x00000002): quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
// - DIV 7/-2: quotient 0xFFFFFFFD; REM gives 0x00000001.
// - Divide by zero, dividend 0x12345678:
//   - DIVU gives 0xFFFFFFFF; REMU gives 0x12345678.
//   - ready_o rises 1 cycle after start.
// - Signed overflow 0x80000000/0xFFFFFFFF:
//   - DIV gives 0x80000000, REM gives 0, 1-cycle latency.
//   - DIVU of the same operands runs 33 cycles and gives 0x00000000.
// - annul_i pulse at cycle 10 of CALC: IDLE next edge, ready_o never rises.
//   - Then start DIVU 0xFFFFFFFF/1: result 0xFFFFFFFF after 33 cycles.
// - Async reset asserted mid-CALC between clock edges:
//   - ready_o/result_o go to 0 immediately.
//   - After release, a new op completes normally.

Source files
------------

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Normal ops take WIDTH+1 cycles to ready_o; divide-by-zero and signed overflow take 1.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             rem_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             stall_req_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;
  logic             rem_sel;

  logic             neg_dd;
  logic             neg_ds;
  logic             ovf;
  logic [WIDTH-1:0] abs_dd;
  logic [WIDTH-1:0] abs_ds;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  assign neg_dd = signed_i & dividend_i[WIDTH-1];
  assign neg_ds = signed_i & divisor_i[WIDTH-1];
  // |MIN_INT| wraps back to MIN_INT, which is the correct unsigned magnitude
  assign abs_dd = neg_dd ? -dividend_i : dividend_i;
  assign abs_ds = neg_ds ? -divisor_i : divisor_i;
  assign ovf    = signed_i & (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&divisor_i);

  // One extra bit: the shifted partial remainder can exceed WIDTH bits for large divisors
  assign shifted = {rem_r, quo_r[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};

  assign fix_q = neg_q ? -quo_r : quo_r;
  assign fix_r = neg_r ? -rem_r : rem_r;

  assign stall_req_o = start_i & ~ready_o & ~annul_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_r    <= '0;
      quo_r    <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      rem_sel  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i) begin
            rem_sel <= rem_i;
            cnt     <= '0;
            if (divisor_i == '0) begin
              quo_r <= '1;
              rem_r <= dividend_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else if (ovf) begin
              quo_r <= {1'b1, {(WIDTH-1){1'b0}}};
              rem_r <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              quo_r <= abs_dd;
              rem_r <= '0;
              dvsr  <= abs_ds;
              neg_q <= neg_dd ^ neg_ds;
              neg_r <= neg_dd;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!start_i) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            if (!diff[WIDTH]) begin
              rem_r <= diff[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
              rem_r <= shifted[WIDTH-1:0];
              quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state    <= IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o  <= 1'b1;
            result_o <= rem_sel ? fix_r : fix_q;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: expected results are queued at start and popped when ready_o rises.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        rem_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        stall_req_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .rem_i       (rem_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic sgn, input logic rm,
                                          input logic [31:0] a, input logic [31:0] b);
    if (b == 32'h0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
      return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rm ? a % b : a / b;
  endfunction

  function automatic bit is_special(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic run_op(input logic sgn, input logic rm, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int stalls;
    int exp_lat;
    logic [31:0] exp;
    exp_lat = is_special(sgn, a, b) ? 1 : 33;
    exp_q.push_back(ref_div(sgn, rm, a, b));
    @(posedge clk); #1;
    signed_i = sgn; rem_i = rm; dividend_i = a; divisor_i = b; start_i = 1'b1;
    lat = -1;
    stalls = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!ready_o && stall_req_o) stalls++;
      // Operands must be latched; scramble the inputs while the op runs
      dividend_i = $urandom; divisor_i = $urandom; signed_i = ~sgn; rem_i = ~rm;
    end while (!ready_o && lat < 100);
    check("ready_timeout", {31'b0, ready_o}, 32'd1);
    check("latency", lat, exp_lat);
    check("stall_cycles", stalls, exp_lat);
    check("stall_at_ready", {31'b0, stall_req_o}, 32'd0);
    exp = exp_q.pop_front();
    check("result", result_o, exp);
    @(posedge clk); #1;
    check("done_hold_rdy", {31'b0, ready_o}, 32'd1);
    check("done_hold_res", result_o, exp);
    start_i = 1'b0;
    @(posedge clk); #1;
    check("idle_rdy", {31'b0, ready_o}, 32'd0);
    check("idle_res", result_o, 32'h0);
  endtask

  task automatic abort_op(input logic use_annul, input int n);
    int seen;
    @(posedge clk); #1;
    signed_i = 1'b0; rem_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    if (use_annul) begin
      annul_i = 1'b1;
      #1;
      check("stall_annul", {31'b0, stall_req_o}, 32'd0);
      @(posedge clk); #1;
      annul_i = 1'b0;
    end
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o || result_o != 32'h0) seen++;
    end
    check(use_annul ? "annul_no_ready" : "drop_no_ready", seen, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; rem_i = 1'b0;
    dividend_i = 32'h0; divisor_i = 32'h0; annul_i = 1'b0;
    #1;
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_stall", {31'b0, stall_req_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(1'b0, 1'b0, 32'd100, 32'd7);
    run_op(1'b0, 1'b1, 32'd100, 32'd7);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'h0);
    run_op(1'b0, 1'b1, 32'h1234_5678, 32'h0);
    run_op(1'b1, 1'b0, 32'h1234_5678, 32'h0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd3);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'd3);
    for (int i = 0; i < 6; i++) begin
      run_op(1'($urandom), 1'($urandom), $urandom, $urandom_range(1, 65535));
    end

    abort_op(1'b1, 11);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    abort_op(1'b0, 6);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd10);

    // Async reset between edges, first mid-CALC then with a result on the outputs
    @(posedge clk); #1;
    signed_i = 1'b0; rem_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("arst_calc_rdy", {31'b0, ready_o}, 32'd0);
    check("arst_calc_res", result_o, 32'h0);
    #2 rst = 1'b0; start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("pre_arst_rdy", {31'b0, ready_o}, 32'd1);
    check("pre_arst_res", result_o, 32'd14);
    #3 rst = 1'b1;
    #1;
    check("arst_done_rdy", {31'b0, ready_o}, 32'd0);
    check("arst_done_res", result_o, 32'h0);
    #2 rst = 1'b0; start_i = 1'b0;
    run_op(1'b0, 1'b0, 32'd100, 32'd7);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
